axi_burst_addr_gen: RTL and testbench

Parametrised AXI burst address generator. Accepts one AW/AR-style request (address, ID, len, size, burst) on a valid/ready handshake and emits one registered beat descriptor per transfer: beat address, byte-lane offset, index, last and error flags. It sits between a slave's address-channel skid buffer and its data-path/memory controller, and serves both read and write sides through separate instances. It supports FIXED, INCR and WRAP bursts with AXI4 protocol checks.

---
 rtl/axi_burst_addr_gen_pkg.sv | 27 ++
 rtl/axi_burst_addr_gen_if.sv | 46 ++++
 rtl/axi_burst_addr_gen_next_addr.sv | 39 +++
 rtl/axi_burst_addr_gen.sv | 139 +++++++++++++
 tb/tb_axi_burst_addr_gen.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_burst_addr_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_burst_addr_gen_pkg : shared burst types, codes and FSM states      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package axi_burst_addr_gen_pkg;

  typedef logic [7:0] len_type;
  typedef logic [2:0] size_type;
  typedef logic [1:0] burst_type;

  localparam burst_type BURST_FIXED = 2'b00;
  localparam burst_type BURST_INCR  = 2'b01;
  localparam burst_type BURST_WRAP  = 2'b10;
  localparam burst_type BURST_RSVD  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic wrap_len_ok(input len_type len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_burst_addr_gen_if : request and beat-descriptor channel bundle     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface axi_burst_addr_gen_if
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  localparam int LANE_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ID_WIDTH-1:0]   req_id;
  len_type               req_len;
  size_type              req_size;
  burst_type             req_burst;

  logic                  beat_valid;
  logic                  beat_ready;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [LANE_WIDTH-1:0] beat_lane;
  logic [ID_WIDTH-1:0]   beat_id;
  logic [7:0]            beat_idx;
  logic                  beat_last;
  logic                  beat_err;
  logic                  busy;

  modport slave (
    input  req_valid, req_addr, req_id, req_len, req_size, req_burst, beat_ready,
    output req_ready, beat_valid, beat_addr, beat_lane, beat_id, beat_idx,
    output beat_last, beat_err, busy
  );

  modport master (
    output req_valid, req_addr, req_id, req_len, req_size, req_burst, beat_ready,
    input  req_ready, beat_valid, beat_addr, beat_lane, beat_id, beat_idx,
    input  beat_last, beat_err, busy
  );

endinterface
`default_nettype wire

// File: rtl/axi_burst_addr_gen_next_addr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_next_addr : combinational next-beat address for FIXED/INCR/WRAP    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axi_next_addr
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  len_type               len,
  input  size_type              size,
  input  burst_type             burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_wrap_bytes;
  logic [ADDR_WIDTH-1:0] w_lower;
  logic [ADDR_WIDTH-1:0] w_incr;

  always_comb begin
    w_bytes      = ONE << size;
    w_wrap_bytes = (ADDR_WIDTH'(len) + ONE) << size;
    w_lower      = addr & ~(w_wrap_bytes - ONE);
    w_incr       = addr + w_bytes;
    next_addr    = addr;
    case (burst)
      BURST_INCR: next_addr = (addr & ~(w_bytes - ONE)) + w_bytes;
      // Wrap back to the window base once the increment reaches its top.
      BURST_WRAP: next_addr = (w_incr == (w_lower + w_wrap_bytes)) ? w_lower : w_incr;
      default:    next_addr = addr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_burst_addr_gen : one AW/AR request in, one beat descriptor per beat |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axi_burst_addr_gen
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_burst_addr_gen_if.slave  bus
);
  localparam int LANE_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;
  localparam int MAX_SIZE   = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]   id;
    logic [7:0]            idx;
    logic                  last;
    logic                  err;
  } beat_t;

  state_t                r_state;
  state_t                w_next_state;
  beat_t                 r_beat;
  len_type               r_len;
  size_type              r_size;
  burst_type             r_burst;
  logic                  w_load;
  logic                  w_advance;
  logic                  w_req_err;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH-1:0] w_req_mask;
  logic [ADDR_WIDTH-1:0] w_incr_final;

  // Request-time protocol checks; result is frozen for the whole burst.
  always_comb begin
    w_req_mask   = (ONE << bus.req_size) - ONE;
    w_incr_final = (bus.req_addr & ~w_req_mask) + (ADDR_WIDTH'(bus.req_len) << bus.req_size);
    w_req_err    = 1'b0;
    if (bus.req_burst == BURST_RSVD)
      w_req_err = 1'b1;
    if ((bus.req_burst == BURST_WRAP) && !wrap_len_ok(bus.req_len))
      w_req_err = 1'b1;
    if ((bus.req_burst == BURST_WRAP) && ((bus.req_addr & w_req_mask) != '0))
      w_req_err = 1'b1;
    if (int'(bus.req_size) > MAX_SIZE)
      w_req_err = 1'b1;
    if ((bus.req_burst == BURST_INCR) && ((bus.req_addr >> 12) != (w_incr_final >> 12)))
      w_req_err = 1'b1;
  end

  axi_next_addr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_addr (
    .addr      (r_beat.addr),
    .len       (r_len),
    .size      (r_size),
    .burst     (r_burst),
    .next_addr (w_next_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state   = r_state;
    w_load         = 1'b0;
    w_advance      = 1'b0;
    bus.req_ready  = 1'b0;
    bus.beat_valid = 1'b0;
    bus.busy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = !rst;
        if (bus.req_valid) begin
          w_load       = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        bus.beat_valid = 1'b1;
        bus.busy       = 1'b1;
        if (bus.beat_ready) begin
          if (r_beat.last) w_next_state = ST_IDLE;
          else             w_advance    = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= BURST_FIXED;
    end else if (w_load) begin
      r_beat.addr <= bus.req_addr;
      r_beat.id   <= bus.req_id;
      r_beat.idx  <= 8'd0;
      r_beat.last <= (bus.req_len == 8'd0);
      r_beat.err  <= w_req_err;
      r_len       <= bus.req_len;
      r_size      <= bus.req_size;
      // Reserved encoding walks like FIXED.
      r_burst     <= (bus.req_burst == BURST_RSVD) ? BURST_FIXED : bus.req_burst;
    end else if (w_advance) begin
      r_beat.addr <= w_next_addr;
      r_beat.idx  <= r_beat.idx + 8'd1;
      r_beat.last <= ((r_beat.idx + 8'd1) == r_len);
    end
  end

  assign bus.beat_addr = r_beat.addr;
  assign bus.beat_id   = r_beat.id;
  assign bus.beat_idx  = r_beat.idx;
  assign bus.beat_last = r_beat.last;
  assign bus.beat_err  = r_beat.err;

  generate
    if (DATA_WIDTH > 8) begin : g_lane
      assign bus.beat_lane = r_beat.addr[LANE_WIDTH-1:0];
    end else begin : g_lane_byte
      assign bus.beat_lane = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_burst_addr_gen : directed and random bursts vs behavioural model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_axi_burst_addr_gen;
  import axi_burst_addr_gen_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int IW    = 4;
  localparam int LANES = DW / 8;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    int          idx;
    bit          last;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   hs_cnt = 0;
  bit   mdl_busy = 1'b0;
  bit   mdl_zero = 1'b1;
  exp_t exp_q[$];

  axi_burst_addr_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) ifc ();

  axi_burst_addr_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Address of beat k, straight from the burst rules.
  function automatic logic [31:0] model_addr(input logic [31:0] a, input int len,
                                             input int size, input int burst, input int k);
    logic [31:0] bytes, wb, lower, cur;
    bytes = 32'd1 << size;
    if (k == 0) return a;
    if (burst == 1) return (a & ~(bytes - 32'd1)) + bytes * k;
    if (burst == 2) begin
      wb    = bytes * (len + 1);
      lower = a & ~(wb - 32'd1);
      cur   = a;
      for (int i = 0; i < k; i++) begin
        cur = cur + bytes;
        if (cur == lower + wb) cur = lower;
      end
      return cur;
    end
    return a;
  endfunction

  function automatic bit model_err(input logic [31:0] a, input int len,
                                   input int size, input int burst);
    logic [31:0] bytes, fin;
    bit e;
    bytes = 32'd1 << size;
    fin   = model_addr(a, len, size, burst, len);
    e = (burst == 3);
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) e = 1'b1;
    if (burst == 2 && (a & (bytes - 32'd1)) != 32'd0) e = 1'b1;
    if (bytes > LANES) e = 1'b1;
    if (burst == 1 && a[31:12] != fin[31:12]) e = 1'b1;
    return e;
  endfunction

  function automatic void build(input logic [31:0] a, input logic [3:0] id, input int len,
                                input int size, input int burst);
    exp_t e;
    bit   er;
    er = model_err(a, len, size, burst);
    for (int k = 0; k <= len; k++) begin
      e.addr = model_addr(a, len, size, burst, k);
      e.id   = id;
      e.idx  = k;
      e.last = (k == len);
      e.err  = er;
      exp_q.push_back(e);
    end
  endfunction

  // Compare outputs mid-cycle, then predict what the coming edge does.
  always @(negedge clk) begin
    exp_t e;
    chk("req_ready", {63'd0, ifc.req_ready}, {63'd0, (!mdl_busy && !rst)});
    chk("beat_valid", {63'd0, ifc.beat_valid}, {63'd0, mdl_busy});
    chk("busy", {63'd0, ifc.busy}, {63'd0, mdl_busy});
    if (mdl_busy) begin
      e = exp_q[0];
      chk("beat_addr", 64'(ifc.beat_addr), 64'(e.addr));
      chk("beat_lane", 64'(ifc.beat_lane), 64'(e.addr % LANES));
      chk("beat_id",   64'(ifc.beat_id),   64'(e.id));
      chk("beat_idx",  64'(ifc.beat_idx),  64'(e.idx));
      chk("beat_last", 64'(ifc.beat_last), 64'(e.last));
      chk("beat_err",  64'(ifc.beat_err),  64'(e.err));
    end else if (mdl_zero) begin
      chk("rst_beat_fields",
          {ifc.beat_addr, 4'(ifc.beat_lane), ifc.beat_id, ifc.beat_idx, 6'd0,
           ifc.beat_last, ifc.beat_err}, 64'd0);
    end
    if (rst) begin
      mdl_busy = 1'b0;
      mdl_zero = 1'b1;
      exp_q.delete();
    end else if (!mdl_busy) begin
      if (ifc.req_valid) begin
        build(ifc.req_addr, ifc.req_id, int'(ifc.req_len), int'(ifc.req_size),
              int'(ifc.req_burst));
        mdl_busy = 1'b1;
        mdl_zero = 1'b0;
      end
    end else if (ifc.beat_ready) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) mdl_busy = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst && ifc.beat_valid && ifc.beat_ready) hs_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [3:0] id, input int len,
                      input int size, input int burst);
    int  n;
    bit  ok;
    n = 0;
    ifc.req_valid = 1'b1;
    ifc.req_addr  = a;
    ifc.req_id    = id;
    ifc.req_len   = 8'(len);
    ifc.req_size  = 3'(size);
    ifc.req_burst = 2'(burst);
    forever begin
      #1;
      ok = ifc.req_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 500) begin
        n_checks++;
        n_errors++;
        $display("FAIL req_accept_timeout: req_ready stayed 0, required 1");
        break;
      end
    end
    ifc.req_valid = 1'b0;
    ifc.req_addr  = $urandom;
    ifc.req_id    = 4'($urandom);
    ifc.req_len   = 8'($urandom);
    ifc.req_size  = 3'($urandom);
    ifc.req_burst = 2'($urandom);
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while (mdl_busy && n < 3000) begin
      ifc.beat_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      n++;
    end
    if (mdl_busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL burst_done_timeout: model still busy after %0d cycles, required idle", n);
      mdl_busy = 1'b0;
      exp_q.delete();
    end
  endtask

  initial begin
    logic [31:0] wrap_exp[4];
    logic [31:0] incr_exp[3];
    logic [31:0] a;
    int          hs0, n, len, size, burst;

    ifc.req_valid  = 1'b0;
    ifc.req_addr   = '0;
    ifc.req_id     = '0;
    ifc.req_len    = '0;
    ifc.req_size   = '0;
    ifc.req_burst  = '0;
    ifc.beat_ready = 1'b0;

    // Hand-computed anchors for the model.
    wrap_exp = '{32'h38, 32'h20, 32'h28, 32'h30};
    for (int k = 0; k < 4; k++)
      chk($sformatf("pin_wrap_addr%0d", k), 64'(model_addr(32'h38, 3, 3, 2, k)), 64'(wrap_exp[k]));
    chk("pin_wrap_err", 64'(model_err(32'h38, 3, 3, 2)), 64'd0);
    incr_exp = '{32'h1003, 32'h1004, 32'h1008};
    for (int k = 0; k < 3; k++)
      chk($sformatf("pin_incr_addr%0d", k), 64'(model_addr(32'h1003, 2, 2, 1, k)), 64'(incr_exp[k]));
    chk("pin_4k_addr1", 64'(model_addr(32'hFF8, 1, 3, 1, 1)), 64'h1000);
    chk("pin_4k_err", 64'(model_err(32'hFF8, 1, 3, 1)), 64'd1);
    chk("pin_rsvd_err", 64'(model_err(32'h100, 0, 2, 3)), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_req_ready", {63'd0, ifc.req_ready}, 64'd1);
    chk("reset_beat_valid", {63'd0, ifc.beat_valid}, 64'd0);
    step();

    ifc.beat_ready = 1'b1;
    send(32'h38, 4'h1, 3, 3, 2);            wait_idle(1'b0);
    send(32'h1003, 4'h2, 2, 2, 1);          wait_idle(1'b0);
    send(32'hFF8, 4'h3, 1, 3, 1);           wait_idle(1'b0);
    send(32'h100, 4'h4, 0, 2, 3);           wait_idle(1'b0);

    // Backpressure on beat 1 of a FIXED burst.
    ifc.beat_ready = 1'b0;
    hs0 = hs_cnt;
    send(32'h40, 4'h5, 3, 3, 0);
    ifc.beat_ready = 1'b1;
    step();
    ifc.beat_ready = 1'b0;
    repeat (3) begin
      step();
      chk("bp_hold_idx", 64'(ifc.beat_idx), 64'd1);
      chk("bp_hold_addr", 64'(ifc.beat_addr), 64'h40);
    end
    wait_idle(1'b0);
    chk("bp_handshakes", 64'(hs_cnt - hs0), 64'd4);

    // Reset in the middle of a long INCR burst.
    ifc.beat_ready = 1'b1;
    send(32'h2000, 4'h6, 15, 2, 1);
    n = 0;
    while (!(ifc.beat_valid && ifc.beat_idx == 8'd5) && n < 100) begin
      step();
      n++;
    end
    chk("mid_rst_reached_idx5", 64'(ifc.beat_idx), 64'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_beat_valid", {63'd0, ifc.beat_valid}, 64'd0);
    chk("mid_rst_beat_addr", 64'(ifc.beat_addr), 64'd0);
    send(32'h3004, 4'h7, 2, 2, 1);          wait_idle(1'b0);

    // Random bursts with random downstream backpressure.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = {$urandom_range(0, 15) * 32'h1000} - 32'($urandom_range(0, 64));
        2:       a = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
        default: a = 32'($urandom_range(0, 255)) << $urandom_range(0, 4);
      endcase
      len   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      size  = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      burst = $urandom_range(0, 3);
      if (burst == 2 && $urandom_range(0, 1) == 1) begin
        len = (2 << $urandom_range(0, 3)) - 1;
        a   = a & ~((32'd1 << size) - 32'd1);
      end
      send(a, 4'($urandom), len, size, burst);
      wait_idle(1'b1);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
